// File: rtl/bram_frame_ctrl.sv
// Frame controller for a single-port, fixed-latency BRAM: captures one frame
// from an upstream valid/ready stream, then plays it back in address order
// through a small credit-managed output FIFO.
module bram_frame_ctrl #(
    parameter int RAM_WIDTH    = 8,
    parameter int RAM_DEPTH    = 307200,
    parameter int ADDR_WIDTH   = 19,
    parameter int READ_LATENCY = 2,
    parameter int OFIFO_DEPTH  = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iStart,
    input  logic                  iWrValid,
    input  logic [RAM_WIDTH-1:0]  iWrData,
    output logic                  oWrReady,
    output logic                  oRdValid,
    output logic [RAM_WIDTH-1:0]  oRdData,
    input  logic                  iRdReady,
    output logic                  oBramEn,
    output logic                  oBramWe,
    output logic [ADDR_WIDTH-1:0] oBramAddr,
    output logic [RAM_WIDTH-1:0]  oBramDin,
    input  logic [RAM_WIDTH-1:0]  iBramDout,
    output logic                  oBusy,
    output logic                  oFrameDone
);

    localparam int PTR_W = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(OFIFO_DEPTH + 1);
    localparam int INF_W = $clog2(READ_LATENCY + 1);
    localparam int OCC_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [OCC_W-1:0]      FIFO_CAP  = OCC_W'(OFIFO_DEPTH);
    localparam logic [CNT_W-1:0]      FIFO_FULL = CNT_W'(OFIFO_DEPTH);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(OFIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0]   wr_cnt, rd_cnt;
    logic [READ_LATENCY-1:0] inflight_sr;
    logic [INF_W-1:0]        inflight;

    logic [RAM_WIDTH-1:0]    fifo_mem [OFIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fifo_count;

    logic wr_xfer;
    logic rd_issue;
    logic has_credit;
    logic fifo_push;
    logic fifo_pop;

    // Number of issued reads whose data has not yet come back from the BRAM
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + INF_W'(inflight_sr[i]);
        end
    end

    // Credit exists while FIFO contents plus reads in flight leave a free slot;
    // a pop in the same cycle is deliberately not counted, so a full FIFO can
    // never be overrun by a late return.
    assign has_credit = (OCC_W'(fifo_count) + OCC_W'(inflight)) < FIFO_CAP;
    assign fifo_push  = inflight_sr[READ_LATENCY-1];
    assign oRdValid   = (fifo_count != '0);
    assign oRdData    = fifo_mem[rd_ptr];
    assign fifo_pop   = oRdValid && iRdReady;

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and BRAM/handshake outputs
    always_comb begin
        next_state = state;
        oWrReady   = 1'b0;
        oBramEn    = 1'b0;
        oBramWe    = 1'b0;
        oBramAddr  = '0;
        oBramDin   = '0;
        oBusy      = 1'b1;
        oFrameDone = 1'b0;
        wr_xfer    = 1'b0;
        rd_issue   = 1'b0;
        case (state)
            S_IDLE: begin
                oBusy = 1'b0;
                if (iStart) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                oWrReady = 1'b1;
                if (iWrValid) begin
                    wr_xfer   = 1'b1;
                    oBramEn   = 1'b1;
                    oBramWe   = 1'b1;
                    oBramAddr = wr_cnt;
                    oBramDin  = iWrData;
                    if (wr_cnt == LAST_ADDR) begin
                        next_state = S_READ;
                    end
                end
            end
            S_READ: begin
                if (has_credit) begin
                    rd_issue  = 1'b1;
                    oBramEn   = 1'b1;
                    oBramAddr = rd_cnt;
                    if (rd_cnt == LAST_ADDR) begin
                        next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight_sr == '0) && (fifo_count == '0)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                oFrameDone = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                oBusy      = 1'b0;
                next_state = S_IDLE;
            end
        endcase
    end

    // Write address counter, cleared when a frame starts
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_cnt <= '0;
        end else if ((state == S_IDLE) && iStart) begin
            wr_cnt <= '0;
        end else if (wr_xfer) begin
            wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
        end
    end

    // Read address counter, cleared on the WRITE to READ hand-over
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rd_cnt <= '0;
        end else if ((state == S_WRITE) && (next_state == S_READ)) begin
            rd_cnt <= '0;
        end else if (rd_issue) begin
            rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
        end
    end

    // Read-valid shift register mirroring the BRAM pipeline; its top bit marks returning data
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            inflight_sr <= '0;
        end else begin
            inflight_sr <= (inflight_sr << 1) | READ_LATENCY'(rd_issue);
        end
    end

    // Output FIFO storage and pointers; simultaneous push and pop leave the count unchanged
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < OFIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= iBramDout;
                wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The credit scheme must never let a return land in a full FIFO
    a_no_overflow: assert property (@(posedge iClk) disable iff (iRst)
        !(fifo_push && !fifo_pop && (fifo_count == FIFO_FULL)));

    // Write enable is only ever qualified by the BRAM enable
    a_we_needs_en: assert property (@(posedge iClk) disable iff (iRst)
        !(oBramWe && !oBramEn));

endmodule

// File: tb/tb_bram_frame_ctrl.sv
// Self-checking bench for bram_frame_ctrl: behavioural BRAM with two-cycle
// read latency, a pixel scoreboard filled on accepted writes and drained on
// output handshakes, plus per-frame protocol checks.
module tb_bram_frame_ctrl;

    localparam int W     = 8;
    localparam int DEPTH = 100;
    localparam int AW    = 19;
    localparam int LAT   = 2;
    localparam int FD    = 4;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          iStart = 1'b0;
    logic          iWrValid = 1'b0;
    logic [W-1:0]  iWrData = '0;
    logic          oWrReady;
    logic          oRdValid;
    logic [W-1:0]  oRdData;
    logic          iRdReady = 1'b0;
    logic          oBramEn;
    logic          oBramWe;
    logic [AW-1:0] oBramAddr;
    logic [W-1:0]  oBramDin;
    logic [W-1:0]  iBramDout;
    logic          oBusy;
    logic          oFrameDone;

    bram_frame_ctrl #(
        .RAM_WIDTH   (W),
        .RAM_DEPTH   (DEPTH),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(LAT),
        .OFIFO_DEPTH (FD)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iWrValid  (iWrValid),
        .iWrData   (iWrData),
        .oWrReady  (oWrReady),
        .oRdValid  (oRdValid),
        .oRdData   (oRdData),
        .iRdReady  (iRdReady),
        .oBramEn   (oBramEn),
        .oBramWe   (oBramWe),
        .oBramAddr (oBramAddr),
        .oBramDin  (oBramDin),
        .iBramDout (iBramDout),
        .oBusy     (oBusy),
        .oFrameDone(oFrameDone)
    );

    always #5 iClk = ~iClk;

    // Behavioural single-port BRAM, two-cycle read latency
    logic [W-1:0] bram [0:127];
    logic [W-1:0] rd_s1 = '0;
    logic [W-1:0] rd_s2 = '0;
    always @(posedge iClk) begin
        if (oBramEn && oBramWe) bram[oBramAddr[6:0]] <= oBramDin;
        if (oBramEn && !oBramWe) rd_s1 <= bram[oBramAddr[6:0]];
        rd_s2 <= rd_s1;
    end
    assign iBramDout = rd_s2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and per-frame monitor state
    logic [W-1:0] exp_q[$];
    bit   armed = 1'b0;
    bit   bp_mode = 1'b0;
    int   cyc = 0;
    int   wr_addr_exp, rd_addr_exp, issued, popped, done_cnt;
    int   run, max_run, first_issue_cyc, first_valid_cyc, last_wr_cyc;
    bit   prev_stall, prev_done;
    logic [W-1:0] prev_data;

    task automatic new_frame();
        exp_q.delete();
        wr_addr_exp = 0; rd_addr_exp = 0; issued = 0; popped = 0; done_cnt = 0;
        run = 0; max_run = 0; first_issue_cyc = -1; first_valid_cyc = -1; last_wr_cyc = 0;
        prev_stall = 1'b0; prev_done = 1'b0; prev_data = '0;
    endtask

    // Downstream ready: held high, or sparse random when backpressure is on
    initial begin
        forever begin
            @(posedge iClk);
            #1;
            iRdReady = bp_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
        end
    end

    // Monitor sampling on the falling edge
    always @(negedge iClk) begin
        cyc++;
        if (armed && iRst) begin
            new_frame();
        end else if (armed) begin
            check("we_without_en", oBramWe && !oBramEn, 0);
            check("occupancy", (issued - popped) <= FD, 1);
            if (oBramEn && oBramWe) check("wr_strobe_accepted", iWrValid && oWrReady, 1);
            if (iWrValid && oWrReady) begin
                check("wr_en_we", {oBramEn, oBramWe}, 2'b11);
                check("wr_addr", oBramAddr, wr_addr_exp);
                check("wr_din", oBramDin, iWrData);
                exp_q.push_back(iWrData);
                wr_addr_exp++;
                last_wr_cyc = cyc;
            end
            if (oBramEn && !oBramWe) begin
                if (issued == 0) begin
                    first_issue_cyc = cyc;
                    check("first_issue_gap", cyc - last_wr_cyc, 1);
                end
                check("rd_addr", oBramAddr, rd_addr_exp);
                rd_addr_exp++;
                issued++;
            end
            if (prev_stall) begin
                check("stall_valid", oRdValid, 1);
                check("stall_data", oRdData, prev_data);
            end
            if (oRdValid) begin
                if (first_valid_cyc < 0) begin
                    first_valid_cyc = cyc;
                    check("rd_latency", cyc - first_issue_cyc, LAT + 1);
                end
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (oRdValid && iRdReady) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("rd_data", oRdData, exp_q.pop_front());
                popped++;
            end
            if (prev_done) check("busy_after_done", oBusy, 0);
            if (oFrameDone) done_cnt++;
            prev_done  = oFrameDone;
            prev_stall = oRdValid && !iRdReady;
            prev_data  = oRdData;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {oWrReady, oRdValid, oBramEn, oBramWe, oBusy, oFrameDone}, 0);
        check({tag, "_addr"}, oBramAddr, 0);
        check({tag, "_data"}, {oRdData, oBramDin}, 0);
    endtask

    // One capture+playback; optional write gaps, backpressure, stray starts or mid-write reset
    task automatic run_frame(input bit gaps, input bit bp, input int start_at,
                             input bit drain_start, input int abort_at);
        logic [W-1:0] img [DEPTH];
        int  i, n;
        bit  acc, pulsed;
        for (int k = 0; k < DEPTH; k++) img[k] = W'($urandom);
        new_frame();
        bp_mode = bp;
        @(posedge iClk); #1;
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        i = 0; n = 0; pulsed = 1'b0;
        while (i < DEPTH && n < 5000) begin
            if (i == abort_at) begin
                #1;
                iRst = 1'b1;
                #1;
                check_outputs_zero("rst_mid");
                iWrValid = 1'b0;
                repeat (3) @(posedge iClk);
                #1;
                iRst = 1'b0;
                repeat (3) begin
                    @(negedge iClk);
                    check("rst_mid_idle_busy", oBusy, 0);
                    check("rst_mid_no_output", oRdValid, 0);
                end
                return;
            end
            iWrValid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            iWrData  = img[i];
            iStart   = (i == start_at) && !pulsed;
            if (iStart) pulsed = 1'b1;
            @(negedge iClk);
            acc = iWrValid && oWrReady;
            @(posedge iClk); #1;
            if (acc) i++;
            n++;
        end
        iWrValid = 1'b0;
        iStart   = 1'b0;
        check("write_beats_done", i, DEPTH);
        if (drain_start) begin
            n = 0;
            while (issued < DEPTH && n < 4000) begin
                @(posedge iClk); #1;
                n++;
            end
            iStart = 1'b1;
            @(posedge iClk); #1;
            iStart = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(posedge iClk); #1;
            n++;
        end
        check("frame_done_seen", done_cnt > 0, 1);
        repeat (4) @(negedge iClk);
        check("frame_pixels_out", popped, DEPTH);
        check("scoreboard_empty", exp_q.size(), 0);
        check("frame_done_pulses", done_cnt, 1);
        check("wr_beats", wr_addr_exp, DEPTH);
        check("rd_issues", issued, DEPTH);
        if (!bp) check("valid_run", max_run, DEPTH);
        check("busy_idle", oBusy, 0);
        bp_mode = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge iClk);
        #2;
        iRst = 1'b1;
        #1;
        check_outputs_zero("rst_async");
        armed = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        repeat (20) begin
            @(negedge iClk);
            check("idle_busy", oBusy, 0);
            check("idle_wr_ready", oWrReady, 0);
        end
        run_frame(1'b0, 1'b0, -1, 1'b0, -1);
        run_frame(1'b1, 1'b0, -1, 1'b0, -1);
        run_frame(1'b0, 1'b1, -1, 1'b0, -1);
        run_frame(1'b1, 1'b1, -1, 1'b0, -1);
        run_frame(1'b0, 1'b0, 50, 1'b1, -1);
        run_frame(1'b0, 1'b0, -1, 1'b0, 37);
        run_frame(1'b0, 1'b0, -1, 1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
